// File: rtl/tdm_demux.sv
// Receiving end of a slot-per-clock TDM line: locks onto the frame marker,
// steers each bit into its lane and presents whole frames on a registered word.
module tdm_demux #(
  parameter int LANES = 2
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             ng,
  input  logic             sync,
  input  logic             d,
  input  logic             clr_err,
  output logic [LANES-1:0] y,
  output logic             frame,
  output logic [3:0]       slot,
  output logic             locked,
  output logic             err
);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [3:0] LAST_SLOT = 4'(LANES - 1);

  state_t           state_q, state_d;
  logic [3:0]       slot_q, slot_d;
  // The final slot's bit is routed straight into y, so assembly holds only the earlier slots.
  logic [LANES-2:0] asm_q, asm_d;
  logic [LANES-1:0] y_q, y_d;
  logic             frame_q, frame_d;
  logic             err_q, err_d;

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    asm_d   = asm_q;
    y_d     = y_q;
    frame_d = 1'b0;
    err_d   = err_q & ~clr_err;

    if (!ng) begin
      unique case (state_q)
        HUNT: begin
          if (sync) begin
            asm_d[0] = d;
            slot_d   = 4'd1;
            state_d  = LOCKED;
          end
        end
        LOCKED: begin
          if (sync) begin
            // Early sync discards the partial frame and restarts at slot 0.
            if (slot_q != 4'd0) err_d = 1'b1;
            asm_d[0] = d;
            slot_d   = 4'd1;
          end else if (slot_q == 4'd0) begin
            err_d   = 1'b1;
            state_d = HUNT;
          end else if (slot_q == LAST_SLOT) begin
            y_d     = {d, asm_q};
            frame_d = 1'b1;
            slot_d  = 4'd0;
          end else begin
            for (int k = 0; k < LANES - 1; k++) begin
              if (slot_q == 4'(k)) asm_d[k] = d;
            end
            slot_d = slot_q + 4'd1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= HUNT;
      slot_q  <= 4'd0;
      asm_q   <= '0;
      y_q     <= '0;
      frame_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      asm_q   <= asm_d;
      y_q     <= y_d;
      frame_q <= frame_d;
      err_q   <= err_d;
    end
  end

  assign y      = y_q;
  assign frame  = frame_q;
  assign slot   = slot_q;
  assign locked = (state_q == LOCKED);
  assign err    = err_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux (LANES=4): queue-based frame model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_tdm_demux;

  localparam int L = 4;

  logic         clk = 1'b0;
  logic         nreset = 1'b1;
  logic         ng = 1'b0;
  logic         sync = 1'b0;
  logic         d = 1'b0;
  logic         clr_err = 1'b0;
  logic [L-1:0] y;
  logic         frame;
  logic [3:0]   slot;
  logic         locked;
  logic         err;

  int passed = 0;
  int total = 0;
  bit started = 0;

  tdm_demux #(.LANES(L)) dut (
    .clk(clk), .nreset(nreset), .ng(ng), .sync(sync), .d(d), .clr_err(clr_err),
    .y(y), .frame(frame), .slot(slot), .locked(locked), .err(err)
  );

  always #5 clk = ~clk;

  // Model: a frame is just the list of bits collected since the last accepted sync.
  logic         m_bits[$];
  logic         m_locked = 1'b0;
  logic         m_err = 1'b0;
  logic         m_frame = 1'b0;
  logic [L-1:0] m_y = '0;

  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      m_bits.delete();
      m_locked = 1'b0;
      m_err = 1'b0;
      m_frame = 1'b0;
      m_y = '0;
    end else begin
      m_frame = 1'b0;
      if (clr_err) m_err = 1'b0;
      if (!ng) begin
        if (sync) begin
          if (m_locked && m_bits.size() != 0) m_err = 1'b1;
          m_bits.delete();
          m_bits.push_back(d);
          m_locked = 1'b1;
        end else if (m_locked) begin
          if (m_bits.size() == 0) begin
            m_err = 1'b1;
            m_locked = 1'b0;
          end else begin
            m_bits.push_back(d);
            if (m_bits.size() == L) begin
              for (int k = 0; k < L; k++) m_y[k] = m_bits[k];
              m_frame = 1'b1;
              m_bits.delete();
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("model_y", 32'(y), 32'(m_y));
      chk("model_frame", 32'(frame), 32'(m_frame));
      chk("model_slot", 32'(slot), 32'(m_bits.size()));
      chk("model_locked", 32'(locked), 32'(m_locked));
      chk("model_err", 32'(err), 32'(m_err));
    end
  end

  task automatic cyc(input logic s, input logic b, input logic g = 1'b0, input logic c = 1'b0);
    sync = s;
    d = b;
    ng = g;
    clr_err = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string name, input logic [L-1:0] ey, input logic ef,
                         input logic [3:0] es, input logic el, input logic ee);
    chk({name, "_y"}, 32'(y), 32'(ey));
    chk({name, "_frame"}, 32'(frame), 32'(ef));
    chk({name, "_slot"}, 32'(slot), 32'(es));
    chk({name, "_locked"}, 32'(locked), 32'(el));
    chk({name, "_err"}, 32'(err), 32'(ee));
  endtask

  initial begin
    #1 nreset = 1'b0;
    started = 1;
    #1 chk_all("reset", 4'b0000, 1'b0, 4'd0, 1'b0, 1'b0);
    #10 nreset = 1'b1;

    // Single frame 1,0,1,1
    cyc(1, 1); cyc(0, 0); cyc(0, 1);
    chk("f1_no_early_frame", 32'(frame), 32'd0);
    cyc(0, 1);
    chk_all("f1", 4'b1101, 1'b1, 4'd0, 1'b1, 1'b0);

    // Back-to-back frames
    cyc(1, 1); cyc(0, 1); cyc(0, 0); cyc(0, 0);
    chk_all("f2", 4'b0011, 1'b1, 4'd0, 1'b1, 1'b0);
    cyc(1, 0);
    chk("f3_pulse_one_cycle", 32'(frame), 32'd0);
    cyc(0, 1); cyc(0, 0); cyc(0, 1);
    chk_all("f3", 4'b1010, 1'b1, 4'd0, 1'b1, 1'b0);

    // Gated cycles inside a frame
    cyc(1, 1); cyc(0, 0);
    cyc(1, 1, 1'b1); cyc(0, 0, 1'b1); cyc(1, 1, 1'b1);
    chk_all("gated_hold", 4'b1010, 1'b0, 4'd2, 1'b1, 1'b0);
    cyc(0, 1); cyc(0, 1);
    chk_all("gated_frame", 4'b1101, 1'b1, 4'd0, 1'b1, 1'b0);

    // Early sync at slot 2
    cyc(1, 0); cyc(0, 1); cyc(1, 1);
    chk_all("early_sync", 4'b1101, 1'b0, 4'd1, 1'b1, 1'b1);
    cyc(0, 0); cyc(0, 1); cyc(0, 0);
    chk_all("after_early", 4'b0101, 1'b1, 4'd0, 1'b1, 1'b1);
    cyc(1, 1, 1'b0, 1'b1);
    chk("clr_err", 32'(err), 32'd0);
    cyc(0, 1); cyc(0, 1); cyc(0, 0);
    chk("f_after_clr", 32'(y), 32'(4'b0111));

    // Missing sync at slot 0
    cyc(0, 1);
    chk_all("miss_sync", 4'b0111, 1'b0, 4'd0, 1'b0, 1'b1);
    cyc(0, 1); cyc(0, 0);
    chk_all("hunt_ignore", 4'b0111, 1'b0, 4'd0, 1'b0, 1'b1);
    cyc(0, 0, 1'b1, 1'b1);
    chk("clr_while_gated", 32'(err), 32'd0);
    cyc(1, 1); cyc(0, 0); cyc(0, 1); cyc(0, 1);
    chk("relock_frame", 32'(y), 32'(4'b1101));
    cyc(0, 0, 1'b0, 1'b1);
    chk("set_wins_over_clr", 32'(err), 32'd1);
    chk("set_wins_locked", 32'(locked), 32'd0);

    // Asynchronous reset mid-frame
    cyc(0, 0, 1'b0, 1'b1);
    cyc(1, 1); cyc(0, 0);
    chk("pre_reset_slot", 32'(slot), 32'd2);
    #2 nreset = 1'b0;
    #1 chk_all("async_reset", 4'b0000, 1'b0, 4'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1 nreset = 1'b1;
    cyc(0, 1);
    chk("reset_needs_sync", 32'(locked), 32'd0);
    cyc(1, 0); cyc(0, 1); cyc(0, 1); cyc(0, 0);
    chk_all("post_reset_frame", 4'b0110, 1'b1, 4'd0, 1'b1, 1'b0);

    cyc(0, 0, 1'b1);
    #2;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
